fetch_unit: RTL and testbench

Instruction-fetch stage for the WISC-S25 pipeline; it feeds instruction words to the control unit and acts on the control unit's branch and halt decisions. It owns the PC, drives the instruction-memory address, holds the IF/ID pipeline register, and resolves B/BR/HLT in ID using the decoded BranchMux, BranchRegMux and HaltMux. Taken branches and halts redirect or freeze fetch and squash the wrong-path fetch.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// WISC-S25 instruction fetch: owns the PC and the IF/ID register,
// and resolves B/BR/HLT sitting in ID.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        BranchMux,
  input  logic        BranchRegMux,
  input  logic        HaltMux,
  input  logic [2:0]  flags,
  input  logic [15:0] br_reg,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        taken,
  output logic        halted
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pp2;
  logic        r_valid;

  logic        w_z, w_v, w_n;
  logic        w_cond;
  logic [15:0] w_imm;
  logic [15:0] w_tgt;
  logic        w_halt_id;
  logic        w_taken;
  logic [15:0] w_pc_inc;

  // flags arrive as {Z,V,N}
  assign w_z = flags[2];
  assign w_v = flags[1];
  assign w_n = flags[0];

  always_comb begin
    w_cond = 1'b0;
    unique case (r_instr[11:9])
      3'b000: w_cond = ~w_z;
      3'b001: w_cond = w_z;
      3'b010: w_cond = ~w_z & ~w_n;
      3'b011: w_cond = w_n;
      3'b100: w_cond = w_z | (~w_z & ~w_n);
      3'b101: w_cond = w_n | w_z;
      3'b110: w_cond = w_v;
      3'b111: w_cond = 1'b1;
    endcase
  end

  assign w_imm     = {{6{r_instr[8]}}, r_instr[8:0], 1'b0};
  assign w_tgt     = BranchRegMux ? br_reg : r_pp2 + w_imm;
  assign w_halt_id = HaltMux & r_valid;
  assign w_pc_inc  = r_pc + 16'd2;
  assign w_taken   = r_valid & (BranchMux | BranchRegMux)
                   & w_cond & (r_state != S_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_instr <= 16'h0000;
      r_pp2   <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_halt_id) begin
            r_state <= S_HALT;
            r_instr <= 16'h0000;
            r_pp2   <= 16'h0000;
            r_valid <= 1'b0;
          end else if (stall) begin
            r_pc <= r_pc;
          end else if (w_taken) begin
            // redirect and squash the wrong-path word
            r_pc    <= w_tgt;
            r_instr <= 16'h0000;
            r_pp2   <= 16'h0000;
            r_valid <= 1'b0;
          end else begin
            r_pc    <= w_pc_inc;
            r_instr <= imem_data;
            r_pp2   <= w_pc_inc;
            r_valid <= 1'b1;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus2 = r_pp2;
  assign if_id_valid    = r_valid;
  assign taken          = w_taken;
  assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random run,
// all checked against a spec-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        BranchMux;
  logic        BranchRegMux;
  logic        HaltMux;
  logic [2:0]  flags;
  logic [15:0] br_reg;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        taken;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pp2;
  logic        m_valid;
  logic        m_halted;
  logic        e_taken;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .BranchMux(BranchMux), .BranchRegMux(BranchRegMux),
    .HaltMux(HaltMux), .flags(flags), .br_reg(br_reg),
    .if_id_instr(if_id_instr), .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid(if_id_valid), .taken(taken), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ok(logic [2:0] c, logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] target();
    int off;
    if (m_instr[15:12] == 4'hD) return br_reg;
    off = int'(m_instr[8:0]);
    if (off >= 256) off = off - 512;
    return 16'(int'(m_pp2) + 2 * off);
  endfunction

  function automatic logic [15:0] plain_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 11));
    return {op, 12'($urandom)};
  endfunction

  task automatic setup(input logic [15:0] w, input logic st,
                       input logic [2:0] fl, input logic [15:0] br);
    imem_data    = w;
    stall        = st;
    flags        = fl;
    br_reg       = br;
    BranchMux    = (m_instr[15:12] == 4'hC);
    BranchRegMux = (m_instr[15:12] == 4'hD);
    HaltMux      = (m_instr[15:12] == 4'hF);
    e_taken = m_valid && (BranchMux || BranchRegMux)
           && cond_ok(m_instr[11:9], fl) && !m_halted;
    #1;
  endtask

  task automatic clock();
    @(posedge clk);
    if (rst) begin
      m_pc = 16'h0000; m_instr = 0; m_pp2 = 0;
      m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (HaltMux && m_valid) begin
      m_instr = 0; m_valid = 0; m_halted = 1;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (e_taken) begin
      m_pc = target();
      m_instr = 0; m_valid = 0;
    end else begin
      m_pp2 = m_pc + 16'd2;
      m_instr = imem_data;
      m_valid = 1;
      m_pc = m_pc + 16'd2;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    clock();
    rst = 1'b0;
  endtask

  // reach PC=a through an unconditional BR at address 0
  task automatic go_to(input logic [15:0] a);
    do_reset();
    setup(16'hDE00, 1'b0, 3'($urandom), a);
    clock();
    setup(plain_word(), 1'b0, 3'($urandom), a);
    clock();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setup(16'h0123, 1'b0, 3'b000, 16'h0);
    clock();
    n_chk++;
    if (if_id_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got=%b exp=0", if_id_valid);
    end
    rst = 1'b0;
    setup(16'h0123, 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL rst_addr got=%h exp=0000", imem_addr);
    end
    n_chk++;
    if ({if_id_instr, if_id_pc_plus2, halted, taken} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_regs got=%h %h %b %b exp=0",
               if_id_instr, if_id_pc_plus2, halted, taken);
    end
  endtask

  task automatic test_seq();
    clock();
    setup(16'h1456, 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0002 || if_id_instr !== 16'h0123
        || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL seq1 got=%h %h %h %b exp=0002 0123 0002 1",
               imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid);
    end
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0004 || if_id_instr !== 16'h1456
        || if_id_pc_plus2 !== 16'h0004) begin
      n_fail++;
      $display("FAIL seq2 got=%h %h %h exp=0004 1456 0004",
               imem_addr, if_id_instr, if_id_pc_plus2);
    end
  endtask

  task automatic test_b_taken();
    go_to(16'h0010);
    setup(16'hC205, 1'b0, 3'b100, 16'h0);
    clock();
    setup(plain_word(), 1'b0, 3'b100, 16'h0);
    n_chk++;
    if (taken !== 1'b1) begin
      n_fail++; $display("FAIL b_eq_taken got=%b exp=1", taken);
    end
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h001C || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b_eq_target got=%h v=%b exp=001c v=0",
               imem_addr, if_id_valid);
    end
  endtask

  task automatic test_not_taken_back();
    logic [15:0] w;
    go_to(16'h0010);
    setup(16'hC205, 1'b0, 3'b000, 16'h0);
    clock();
    w = plain_word();
    setup(w, 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (taken !== 1'b0) begin
      n_fail++; $display("FAIL b_nt_taken got=%b exp=0", taken);
    end
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0014 || if_id_valid !== 1'b1
        || if_id_instr !== w) begin
      n_fail++;
      $display("FAIL b_nt_next got=%h %b %h exp=0014 1 %h",
               imem_addr, if_id_valid, if_id_instr, w);
    end
    go_to(16'h0020);
    setup(16'hCFFE, 1'b0, 3'($urandom), 16'h0);
    clock();
    setup(plain_word(), 1'b0, 3'($urandom), 16'h0);
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h001E) begin
      n_fail++; $display("FAIL b_back got=%h exp=001e", imem_addr);
    end
  endtask

  task automatic test_br_stall();
    go_to(16'h0030);
    setup(16'hDE30, 1'b0, 3'b000, 16'hBEEF);
    clock();
    for (int i = 0; i < 3; i++) begin
      setup(plain_word(), 1'b1, 3'($urandom), 16'hBEEF);
      n_chk++;
      if (taken !== 1'b1 || imem_addr !== 16'h0032
          || if_id_instr !== 16'hDE30 || if_id_valid !== 1'b1
          || if_id_pc_plus2 !== 16'h0032) begin
        n_fail++;
        $display("FAIL br_stall%0d got=%b %h %h %b exp=1 0032 de30 1",
                 i, taken, imem_addr, if_id_instr, if_id_valid);
      end
      clock();
    end
    setup(plain_word(), 1'b0, 3'b000, 16'hBEEF);
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'hBEEF || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL br_release got=%h %b exp=beef 0",
               imem_addr, if_id_valid);
    end
  endtask

  task automatic test_stall_flags();
    go_to(16'h0050);
    setup(16'hC205, 1'b0, 3'b000, 16'h0);
    clock();
    setup(plain_word(), 1'b1, 3'b100, 16'h0);
    n_chk++;
    if (taken !== 1'b1) begin
      n_fail++; $display("FAIL stall_flag_hi got=%b exp=1", taken);
    end
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    clock();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0054 || if_id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_flag_nt got=%h %b exp=0054 1",
               imem_addr, if_id_valid);
    end
  endtask

  task automatic test_halt();
    go_to(16'h0040);
    setup(16'hF000, 1'b0, 3'b000, 16'h0);
    clock();
    setup(16'hDE00, 1'b1, 3'b000, 16'h0);
    n_chk++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL hlt_early got=%b exp=0", halted);
    end
    clock();
    for (int i = 0; i < 4; i++) begin
      setup(plain_word(), 1'(i), 3'($urandom), 16'h0);
      n_chk++;
      if (halted !== 1'b1 || imem_addr !== 16'h0042
          || if_id_valid !== 1'b0 || taken !== 1'b0) begin
        n_fail++;
        $display("FAIL hlt_frozen%0d got=%b %h %b %b exp=1 0042 0 0",
                 i, halted, imem_addr, if_id_valid, taken);
      end
      clock();
    end
    do_reset();
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (halted !== 1'b0 || imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL hlt_reset got=%b %h exp=0 0000", halted, imem_addr);
    end
  endtask

  task automatic test_wrap_and_rst_branch();
    logic [15:0] w;
    go_to(16'hFFFE);
    w = plain_word();
    setup(w, 1'b0, 3'b000, 16'h0);
    clock();
    setup(16'hDE00, 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0000 || if_id_pc_plus2 !== 16'h0000
        || if_id_instr !== w) begin
      n_fail++;
      $display("FAIL wrap got=%h %h %h exp=0000 0000 %h",
               imem_addr, if_id_pc_plus2, if_id_instr, w);
    end
    clock();
    rst = 1'b1;
    setup(plain_word(), 1'b0, 3'b000, 16'h1234);
    clock();
    rst = 1'b0;
    setup(plain_word(), 1'b0, 3'b000, 16'h0);
    n_chk++;
    if (imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_branch got=%h %b exp=0000 0",
               imem_addr, if_id_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 12) w = {4'hC, 12'($urandom)};
      else if (r < 20) w = {4'hD, 12'($urandom)};
      else if (r < 23) w = 16'hF000;
      else w = plain_word();
      rst = m_halted ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 99) == 0);
      setup(w, $urandom_range(0, 3) == 0, 3'($urandom), 16'($urandom));
      n_chk++;
      if (imem_addr !== m_pc || if_id_valid !== m_valid
          || if_id_instr !== m_instr || taken !== e_taken
          || halted !== m_halted
          || (m_valid && if_id_pc_plus2 !== m_pp2)) begin
        n_fail++;
        $display("FAIL rand%0d got=%h %b %h %h %b %b exp=%h %b %h %h %b %b",
                 i, imem_addr, if_id_valid, if_id_instr, if_id_pc_plus2,
                 taken, halted, m_pc, m_valid, m_instr, m_pp2,
                 e_taken, m_halted);
      end
      clock();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_data = 16'h0; flags = 3'b000;
    br_reg = 16'h0; BranchMux = 0; BranchRegMux = 0; HaltMux = 0;
    m_pc = 0; m_instr = 0; m_pp2 = 0; m_valid = 0; m_halted = 0;
    e_taken = 0;
    #2;
    test_reset();
    test_seq();
    test_b_taken();
    test_not_taken_back();
    test_br_stall();
    test_stall_flags();
    test_halt();
    test_wrap_and_rst_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
